// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, HLT opcode, fetch FSM states and
// small arithmetic helpers used by the fetch front end.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;
    localparam int OPC_W       = 4;

    localparam logic [OPC_W-1:0] HLT_OP = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_e;

    function automatic logic is_hlt(input logic [OPC_W-1:0] opc);
        return (opc == HLT_OP);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous first-word-fall-through FIFO with a single-cycle flush; the head entry
// is read straight out of the storage registers.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointer and occupancy bookkeeping; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage, written without reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_unit.sv
// Decoupled instruction-fetch front end: PC ownership, credit-limited memory requests,
// in-order instruction queue, redirect flush and HLT handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               deq_valid,
    input  logic               deq_ready,
    output logic [INSTR_W-1:0] deq_instr,
    output logic [ADDR_W-1:0]  deq_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               hlt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INSTR_W + ADDR_W;

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [CNT_W-1:0]    r_in_flight;
    logic [CNT_W-1:0]    r_discard;
    logic [CNT_W-1:0]    w_in_flight_nxt;
    logic [CNT_W:0]      w_credit_used;
    logic [CNT_W-1:0]    w_q_count;
    logic [ENT_W-1:0]    w_q_data;
    logic [CNT_W-1:0]    w_tag_count;
    logic [ADDR_W-1:0]   w_tag_head;
    logic                w_grant;
    logic                w_resp;
    logic                w_resp_drop;
    logic                w_resp_keep;
    logic                w_push;
    logic                w_tag_push;
    logic                w_deq_hs;
    logic                w_halt_enter;
    logic                w_kill;

    // Discarded responses still hold credit until they return, so the queue cannot overflow.
    assign w_credit_used = {1'b0, r_in_flight} + {1'b0, w_q_count};
    assign imem_req      = !rst && (r_state == ST_FETCH) && (w_credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign hlt           = (r_state == ST_HALTED);

    assign w_grant      = imem_req && imem_gnt;
    assign w_resp       = imem_rvalid && (r_in_flight != {CNT_W{1'b0}});
    assign w_resp_drop  = w_resp && (r_discard != {CNT_W{1'b0}});
    assign w_resp_keep  = w_resp && (r_discard == {CNT_W{1'b0}}) && (w_tag_count != {CNT_W{1'b0}});
    assign w_deq_hs     = deq_valid && deq_ready;
    assign w_halt_enter = !redirect_valid && (r_state == ST_HALT_WAIT) && w_deq_hs
                          && is_hlt(deq_instr[INSTR_W-1 -: OPC_W]);
    assign w_kill       = redirect_valid || w_halt_enter;
    assign w_push       = w_resp_keep && !w_kill;
    assign w_tag_push   = w_grant && !redirect_valid;

    assign w_in_flight_nxt = r_in_flight + CNT_W'(w_grant) - CNT_W'(w_resp);

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_kill),
        .i_push  (w_tag_push),
        .i_data  (r_pc),
        .i_pop   (w_resp_keep),
        .o_data  (w_tag_head),
        .o_count (w_tag_count)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_kill),
        .i_push  (w_push),
        .i_data  ({imem_rdata, w_tag_head}),
        .i_pop   (w_deq_hs),
        .o_data  (w_q_data),
        .o_count (w_q_count)
    );

    assign deq_valid = (w_q_count != {CNT_W{1'b0}});
    assign deq_instr = w_q_data[ADDR_W +: INSTR_W];
    assign deq_pc    = w_q_data[ADDR_W-1:0];

    // Fetch FSM next state; redirect wins over every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_push && is_hlt(imem_rdata[INSTR_W-1 -: OPC_W])) begin
                        w_state_nxt = ST_HALT_WAIT;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_HALT_WAIT: begin
                    if (w_halt_enter) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_state_nxt = ST_HALT_WAIT;
                    end
                end
                ST_HALTED: w_state_nxt = ST_HALTED;
                default:   w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // State, PC, in-flight and discard registers. On a flush every still-outstanding
    // request, including one granted this cycle, must be dropped when it returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= ADDR_W'(RESET_PC);
            r_in_flight <= {CNT_W{1'b0}};
            r_discard   <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_in_flight <= w_in_flight_nxt;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_grant) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end else begin
                r_pc <= r_pc;
            end
            if (w_kill) begin
                r_discard <= w_in_flight_nxt;
            end else begin
                r_discard <= r_discard - CNT_W'(w_resp_drop);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] w_flush_cnt;
    logic             w_resp_dropped;
    logic [31:0]      r_perf_fetched;
    logic [31:0]      r_perf_flushed;
    logic [31:0]      r_perf_stall;

    // Entries still queued after this cycle's dequeue are the ones a flush throws away.
    always_comb begin
        if (w_kill) begin
            w_flush_cnt = w_q_count - CNT_W'(w_deq_hs);
        end else begin
            w_flush_cnt = {CNT_W{1'b0}};
        end
    end

    assign w_resp_dropped = w_resp && !w_push;

    // Saturating counters; deliberately untouched by redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_flushed <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            r_perf_fetched <= sat_add32(r_perf_fetched, 32'(w_push));
            r_perf_flushed <= sat_add32(r_perf_flushed, 32'(w_flush_cnt) + 32'(w_resp_dropped));
            r_perf_stall   <= sat_add32(r_perf_stall, 32'(imem_req && !imem_gnt));
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
